// File: rtl/rob_multi_commit.sv
// Reorder buffer with out-of-order writeback and up to COMMIT_W in-order retirements per cycle.
// Register results retire to the ARF, stores to dmem, and a mispredicted branch reached by the
// retirement group flushes the whole buffer.
module rob_multi_commit #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned TAG_W    = $clog2(DEPTH),
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_CDB  = 3,
    parameter int unsigned COMMIT_W = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [XLEN-1:0]           disp_pc,
    input  logic [1:0]                disp_type,
    input  logic [5:0]                disp_dest,
    output logic [TAG_W-1:0]          disp_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]   cdb_data,
    input  logic                      br_valid,
    input  logic [TAG_W-1:0]          br_tag,
    input  logic                      br_mispred,
    input  logic [XLEN-1:0]           br_target,
    input  logic                      st_valid,
    input  logic [TAG_W-1:0]          st_tag,
    input  logic [XLEN-1:0]           st_addr,
    input  logic [XLEN-1:0]           st_data,
    input  logic [TAG_W-1:0]          rd_tag1,
    input  logic [TAG_W-1:0]          rd_tag2,
    output logic [XLEN:0]             rd_data1,
    output logic [XLEN:0]             rd_data2,
    output logic [COMMIT_W-1:0]       commit_valid,
    output logic [COMMIT_W*6-1:0]     commit_dest,
    output logic [COMMIT_W*TAG_W-1:0] commit_tag,
    output logic [COMMIT_W*XLEN-1:0]  commit_data,
    output logic                      dmem_we,
    input  logic                      dmem_ready,
    output logic [XLEN-1:0]           store_addr,
    output logic [XLEN-1:0]           store_data,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc,
    output logic [TAG_W:0]            count
);

    localparam logic [1:0] TypeStore  = 2'd2;
    localparam logic [1:0] TypeBranch = 2'd3;

    logic [TAG_W-1:0] head_q, tail_q;
    logic [TAG_W:0]   count_q, count_d;
    logic [DEPTH-1:0] busy_q, done_q, mispred_q;
    logic [1:0]       type_q [DEPTH];
    logic [5:0]       dest_q [DEPTH];
    // data holds the ALU/LOAD result, the branch target, or the store data
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];

    logic             disp_fire;
    logic [COMMIT_W-1:0] retire;
    logic [TAG_W-1:0] slot_idx [COMMIT_W];
    logic [TAG_W:0]   n_ret;
    logic             stop;

    // The PC is not consumed at retirement, so it is not kept in the entry
    logic unused_pc;
    assign unused_pc = ^disp_pc;

    assign disp_ready = (count_q != (TAG_W+1)'(DEPTH));
    assign disp_tag   = tail_q;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign count      = count_q;
    assign rd_data1   = {done_q[rd_tag1], data_q[rd_tag1]};
    assign rd_data2   = {done_q[rd_tag2], data_q[rd_tag2]};

    // Scan the retirement window in order; the first entry that cannot go ends the group
    always_comb begin
        retire       = '0;
        n_ret        = '0;
        stop         = 1'b0;
        flush        = 1'b0;
        flush_pc     = '0;
        dmem_we      = 1'b0;
        store_addr   = '0;
        store_data   = '0;
        commit_valid = '0;
        commit_dest  = '0;
        commit_tag   = '0;
        commit_data  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k] = head_q + TAG_W'(k);
            if (!stop) begin
                if (busy_q[slot_idx[k]] && done_q[slot_idx[k]]) begin
                    if (type_q[slot_idx[k]] == TypeBranch && mispred_q[slot_idx[k]]) begin
                        flush    = 1'b1;
                        flush_pc = data_q[slot_idx[k]];
                        stop     = 1'b1;
                    end else if (type_q[slot_idx[k]] == TypeStore) begin
                        if (k == 0 && dmem_ready) begin
                            retire[k]  = 1'b1;
                            dmem_we    = 1'b1;
                            store_addr = addr_q[slot_idx[k]];
                            store_data = data_q[slot_idx[k]];
                        end
                        stop = 1'b1;
                    end else begin
                        retire[k] = 1'b1;
                        // Correct branches retire silently; ALU/LOAD write the ARF
                        if (type_q[slot_idx[k]] != TypeBranch) begin
                            commit_valid[k]              = 1'b1;
                            commit_dest[k*6 +: 6]        = dest_q[slot_idx[k]];
                            commit_tag[k*TAG_W +: TAG_W] = slot_idx[k];
                            commit_data[k*XLEN +: XLEN]  = data_q[slot_idx[k]];
                        end
                    end
                end else begin
                    stop = 1'b1;
                end
            end
            n_ret = n_ret + (TAG_W+1)'(retire[k]);
        end
    end

    // Occupancy after this cycle's dispatch and retirements
    always_comb begin
        count_d = count_q + (TAG_W+1)'(disp_fire) - n_ret;
    end

    // Entry state: retire, then writebacks (later statements take priority), then dispatch
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= '0;
                dest_q[i] <= '0;
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (flush) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (retire[k]) busy_q[slot_idx[k]] <= 1'b0;
            end
            for (int i = 0; i < NUM_CDB; i++) begin
                if (cdb_valid[i] && busy_q[cdb_tag[i*TAG_W +: TAG_W]]) begin
                    done_q[cdb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
                    data_q[cdb_tag[i*TAG_W +: TAG_W]] <= cdb_data[i*XLEN +: XLEN];
                end
            end
            if (br_valid && busy_q[br_tag]) begin
                done_q[br_tag]    <= 1'b1;
                mispred_q[br_tag] <= br_mispred;
                data_q[br_tag]    <= br_target;
            end
            if (st_valid && busy_q[st_tag]) begin
                done_q[st_tag] <= 1'b1;
                data_q[st_tag] <= st_data;
                addr_q[st_tag] <= st_addr;
            end
            if (disp_fire) begin
                busy_q[tail_q]    <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                mispred_q[tail_q] <= 1'b0;
                type_q[tail_q]    <= disp_type;
                dest_q[tail_q]    <= disp_dest;
                data_q[tail_q]    <= '0;
                addr_q[tail_q]    <= '0;
            end
            head_q  <= head_q + n_ret[TAG_W-1:0];
            tail_q  <= tail_q + TAG_W'(disp_fire);
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit with default parameters (64 entries, 3 CDBs, 2-wide).
module tb_rob_multi_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid;
    logic        disp_ready;
    logic [31:0] disp_pc;
    logic [1:0]  disp_type;
    logic [5:0]  disp_dest;
    logic [5:0]  disp_tag;
    logic [2:0]  cdb_valid;
    logic [17:0] cdb_tag;
    logic [95:0] cdb_data;
    logic        br_valid;
    logic [5:0]  br_tag;
    logic        br_mispred;
    logic [31:0] br_target;
    logic        st_valid;
    logic [5:0]  st_tag;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [5:0]  rd_tag1, rd_tag2;
    logic [32:0] rd_data1, rd_data2;
    logic [1:0]  commit_valid;
    logic [11:0] commit_dest;
    logic [11:0] commit_tag;
    logic [63:0] commit_data;
    logic        dmem_we;
    logic        dmem_ready;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic [6:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rob_multi_commit dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
        .disp_type(disp_type), .disp_dest(disp_dest), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispred(br_mispred), .br_target(br_target),
        .st_valid(st_valid), .st_tag(st_tag), .st_addr(st_addr), .st_data(st_data),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
        .commit_data(commit_data), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .store_addr(store_addr), .store_data(store_data),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    task automatic idle();
        disp_valid = 0; disp_pc = 0; disp_type = 0; disp_dest = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        br_valid = 0; br_tag = 0; br_mispred = 0; br_target = 0;
        st_valid = 0; st_tag = 0; st_addr = 0; st_data = 0;
    endtask

    // Advance one edge; inputs return to idle and outputs settle 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic cdb_write(input int bus, input logic [5:0] tag, input logic [31:0] data);
        cdb_valid[bus]         = 1'b1;
        cdb_tag[bus*6 +: 6]    = tag;
        cdb_data[bus*32 +: 32] = data;
    endtask

    task automatic dispatch(input logic [1:0] t, input logic [5:0] d);
        disp_valid = 1; disp_type = t; disp_dest = d; disp_pc = 32'h1000 + 32'(d);
        step();
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", disp_ready); end
        total++; if (count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL reset_cv got=%b exp=00", commit_valid); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", dmem_we); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
    endtask

    task automatic test_in_order_commit();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp_valid = 1; disp_type = 0; disp_dest = 6'(i + 1); #1;
            total++; if (disp_tag !== 6'(i)) begin bad++; $display("FAIL t1_tag got=%0d exp=%0d", disp_tag, i); end
            step();
        end
        total++; if (count !== 7'd4) begin bad++; $display("FAIL t1_count got=%0d exp=4", count); end
        cdb_write(0, 6'd3, 32'h103); step();
        rd_tag1 = 6'd3; #1;
        total++; if (rd_data1 !== {1'b1, 32'h103}) begin bad++; $display("FAIL t1_rd got=%h exp=%h", rd_data1, {1'b1, 32'h103}); end
        cdb_write(1, 6'd1, 32'h101); step();
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL t1_nocommit got=%b exp=00", commit_valid); end
        cdb_write(2, 6'd0, 32'h100); step();
        total++; if (commit_valid !== 2'b11) begin bad++; $display("FAIL t1_cv01 got=%b exp=11", commit_valid); end
        total++; if (commit_tag !== {6'd1, 6'd0}) begin bad++; $display("FAIL t1_ctag01 got=%h exp=%h", commit_tag, {6'd1, 6'd0}); end
        total++; if (commit_dest !== {6'd2, 6'd1}) begin bad++; $display("FAIL t1_cdest01 got=%h exp=%h", commit_dest, {6'd2, 6'd1}); end
        total++; if (commit_data !== {32'h101, 32'h100}) begin bad++; $display("FAIL t1_cdata01 got=%h exp=%h", commit_data, {32'h101, 32'h100}); end
        step();
        total++; if (count !== 7'd2) begin bad++; $display("FAIL t1_count2 got=%0d exp=2", count); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL t1_wait2 got=%b exp=00", commit_valid); end
        cdb_write(0, 6'd2, 32'h102); step();
        total++; if (commit_valid !== 2'b11) begin bad++; $display("FAIL t1_cv23 got=%b exp=11", commit_valid); end
        total++; if (commit_tag !== {6'd3, 6'd2}) begin bad++; $display("FAIL t1_ctag23 got=%h exp=%h", commit_tag, {6'd3, 6'd2}); end
        step();
        total++; if (count !== 7'd0) begin bad++; $display("FAIL t1_empty got=%0d exp=0", count); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 64; i++) dispatch(2'd0, 6'(i));
        total++; if (count !== 7'd64) begin bad++; $display("FAIL t2_full_count got=%0d exp=64", count); end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL t2_full_ready got=%b exp=0", disp_ready); end
        disp_valid = 1; step();  // refused while full
        total++; if (count !== 7'd64) begin bad++; $display("FAIL t2_refuse got=%0d exp=64", count); end
        cdb_write(0, 6'd0, 32'hA0); cdb_write(1, 6'd1, 32'hA1); step();
        total++; if (commit_valid !== 2'b11) begin bad++; $display("FAIL t2_cv got=%b exp=11", commit_valid); end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL t2_nocredit got=%b exp=0", disp_ready); end
        step();
        total++; if (count !== 7'd62) begin bad++; $display("FAIL t2_count62 got=%0d exp=62", count); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL t2_ready got=%b exp=1", disp_ready); end
        disp_valid = 1; disp_type = 0; disp_dest = 6'd40; #1;
        total++; if (disp_tag !== 6'd0) begin bad++; $display("FAIL t2_wraptag got=%0d exp=0", disp_tag); end
        step();
        rd_tag1 = 6'd0; #1;
        total++; if (rd_data1 !== 33'd0) begin bad++; $display("FAIL t2_reuse got=%h exp=0", rd_data1); end
        total++; if (disp_tag !== 6'd1) begin bad++; $display("FAIL t2_nexttag got=%0d exp=1", disp_tag); end
        total++; if (count !== 7'd63) begin bad++; $display("FAIL t2_count63 got=%0d exp=63", count); end
    endtask

    task automatic test_store_block();
        do_reset();
        dmem_ready = 0;
        dispatch(2'd2, 6'd0);
        dispatch(2'd0, 6'd9);
        st_valid = 1; st_tag = 6'd0; st_addr = 32'h40; st_data = 32'hDEAD;
        cdb_write(0, 6'd1, 32'h55); step();
        for (int i = 0; i < 3; i++) begin
            total++; if (commit_valid !== 2'b00 || dmem_we !== 1'b0) begin bad++; $display("FAIL t3_blocked cv=%b we=%b exp=00/0", commit_valid, dmem_we); end
            step();
        end
        total++; if (count !== 7'd2) begin bad++; $display("FAIL t3_count got=%0d exp=2", count); end
        dmem_ready = 1; #1;
        total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL t3_we got=%b exp=1", dmem_we); end
        total++; if (store_addr !== 32'h40) begin bad++; $display("FAIL t3_addr got=%h exp=40", store_addr); end
        total++; if (store_data !== 32'hDEAD) begin bad++; $display("FAIL t3_data got=%h exp=dead", store_data); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL t3_storecv got=%b exp=00", commit_valid); end
        step();
        total++; if (commit_valid !== 2'b01) begin bad++; $display("FAIL t3_alucv got=%b exp=01", commit_valid); end
        total++; if (commit_tag[5:0] !== 6'd1) begin bad++; $display("FAIL t3_alutag got=%0d exp=1", commit_tag[5:0]); end
        total++; if (commit_data[31:0] !== 32'h55) begin bad++; $display("FAIL t3_aludata got=%h exp=55", commit_data[31:0]); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL t3_we_off got=%b exp=0", dmem_we); end
        step();
        total++; if (count !== 7'd0) begin bad++; $display("FAIL t3_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        do_reset();
        dispatch(2'd0, 6'd7);
        dispatch(2'd3, 6'd0);
        cdb_write(0, 6'd0, 32'h77);
        br_valid = 1; br_tag = 6'd1; br_mispred = 1; br_target = 32'h100; step();
        disp_valid = 1; disp_type = 0; disp_dest = 6'd3; #1;
        total++; if (commit_valid !== 2'b01) begin bad++; $display("FAIL t4_cv got=%b exp=01", commit_valid); end
        total++; if (commit_dest[5:0] !== 6'd7) begin bad++; $display("FAIL t4_dest got=%0d exp=7", commit_dest[5:0]); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL t4_flush got=%b exp=1", flush); end
        total++; if (flush_pc !== 32'h100) begin bad++; $display("FAIL t4_pc got=%h exp=100", flush_pc); end
        step();
        rd_tag1 = 6'd0; rd_tag2 = 6'd1; #1;
        total++; if (count !== 7'd0) begin bad++; $display("FAIL t4_count got=%0d exp=0", count); end
        total++; if (disp_tag !== 6'd0) begin bad++; $display("FAIL t4_tail got=%0d exp=0", disp_tag); end
        total++; if (flush !== 1'b0 || commit_valid !== 2'b00) begin bad++; $display("FAIL t4_after flush=%b cv=%b exp=0/00", flush, commit_valid); end
        total++; if (rd_data1[32] !== 1'b0 || rd_data2[32] !== 1'b0) begin bad++; $display("FAIL t4_done got=%b%b exp=00", rd_data1[32], rd_data2[32]); end
    endtask

    task automatic test_collision();
        do_reset();
        for (int i = 0; i < 6; i++) dispatch(2'd0, 6'(i));
        cdb_write(0, 6'd5, 32'hA); cdb_write(2, 6'd5, 32'hB); step();
        rd_tag1 = 6'd5; #1;
        total++; if (rd_data1 !== {1'b1, 32'hB}) begin bad++; $display("FAIL t5_cdbprio got=%h exp=%h", rd_data1, {1'b1, 32'hB}); end
        cdb_write(2, 6'd4, 32'h44);
        br_valid = 1; br_tag = 6'd4; br_mispred = 0; br_target = 32'h200; step();
        rd_tag2 = 6'd4; #1;
        total++; if (rd_data2 !== {1'b1, 32'h200}) begin bad++; $display("FAIL t5_brprio got=%h exp=%h", rd_data2, {1'b1, 32'h200}); end
        cdb_write(1, 6'd10, 32'hFF); step();
        rd_tag1 = 6'd10; #1;
        total++; if (rd_data1 !== 33'd0) begin bad++; $display("FAIL t5_free got=%h exp=0", rd_data1); end
        total++; if (count !== 7'd6) begin bad++; $display("FAIL t5_count got=%0d exp=6", count); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 10; i++) dispatch(2'd0, 6'(i));
        total++; if (count !== 7'd10) begin bad++; $display("FAIL t6_pre got=%0d exp=10", count); end
        cdb_write(0, 6'd0, 32'h1); cdb_write(1, 6'd1, 32'h2); disp_valid = 1;
        reset = 1; step(); reset = 0;
        rd_tag1 = 6'd0; #1;
        total++; if (count !== 7'd0) begin bad++; $display("FAIL t6_count got=%0d exp=0", count); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL t6_cv got=%b exp=00", commit_valid); end
        total++; if (rd_data1 !== 33'd0) begin bad++; $display("FAIL t6_rd got=%h exp=0", rd_data1); end
    endtask

    initial begin
        reset = 1; dmem_ready = 0; rd_tag1 = 0; rd_tag2 = 0;
        idle();
        test_reset();
        test_in_order_commit();
        test_full_wrap();
        test_store_block();
        test_flush();
        test_collision();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
